mem_lsu: RTL and testbench
==========================

MEM_LSU -- requirements
Module: mem_lsu

Interface
REQ-001 WIDTH, 32, datapath and address width; only 32 is supported.
REQ-002 CLK  in  1  rising-edge clock, single clock domain.
REQ-003 RST_N  in  1  reset, synchronous, active-low.
REQ-004 RegWriteM, ResultSrcM[1:0], MemWriteM, Funct3M[2:0], AluResultM[WIDTH], WriteDataM[WIDTH], RdM[11:7], PCPlus4M[WIDTH]  in  memory-stage controls and data from the execute/memory pipeline register.
REQ-005 DReq, DWe  out  1  data-bus request and write-enable.
REQ-006 DAddr[WIDTH], DBe[4], DWData[WIDTH]  out  bus address (word-aligned), byte enables, and lane-replicated store data.
REQ-007 DGnt, DRValid  in  1  request accepted; read data valid. DRData[WIDTH]  in  read data.
REQ-008 StallM  out  1  freezes the upstream pipeline while an access is pending.
REQ-009 RegWriteW, ResultSrcW[1:0], ReadDataW[WIDTH], AluResultW[WIDTH], RdW[11:7], PCPlus4W[WIDTH]  out  writeback-stage register outputs.

Function
REQ-010 A load is ResultSrcM==2'b01; a store is MemWriteM==1. Neither asserted means no bus activity and no stall.
REQ-011 FSM states IDLE, WAIT_GNT, WAIT_RD. IDLE + access: DReq=1 combinationally in the same cycle.
REQ-012 DGnt=0: go to WAIT_GNT and hold DReq, DWe, DAddr, DBe and DWData stable until DGnt.
REQ-013 Store granted: access complete that cycle, return or stay IDLE, StallM=0 that cycle.
REQ-014 Load granted: go to WAIT_RD with DReq=0. In WAIT_RD, DRValid=1 returns to IDLE with StallM=0 in that cycle.
REQ-015 StallM = access in progress AND NOT completing this cycle. Latency is 0 extra cycles for a store granted immediately and at least 1 cycle for a load.
REQ-016 DAddr = {AluResultM[31:2],2'b00}.
REQ-017 DBe values: sb 4'b0001<<addr[1:0]; sh 4'b0011<<{addr[1],1'b0}; sw 4'b1111.
REQ-018 DWData replicates the byte or half across all lanes.
REQ-019 Load data takes the lane selected by addr[1:0]. Funct3 000 lb (sign-extend), 001 lh (sign-extend), 010 lw, 100 lbu (zero-extend), 101 lhu (zero-extend); other values load the full word.
REQ-020 W register update when StallM=0: capture all M fields into W. ReadDataW is the extended DRData on the completing load cycle and 0 otherwise.
REQ-021 W register update when StallM=1: RegWriteW=0 (bubble); all other W outputs hold.
REQ-022 DRValid in IDLE or WAIT_GNT is ignored.
REQ-023 DGnt and DRValid in the same cycle in IDLE for a load: take the grant; DRValid is ignored.

Reset
REQ-024 RST_N=0 at a clock edge forces state IDLE and DReq=0. All W outputs go to 0.
REQ-025 Reset mid-access abandons the access; any later DRValid for it is ignored (REQ-022).

Configuration
REQ-026 Macro MISALIGN_TRAP_EN.
REQ-027 With MISALIGN_TRAP_EN defined: a half access with addr[0]=1 or a word access with addr[1:0]!=0 issues no DReq and no stall. The instruction passes to W with RegWriteW=0, and an extra output MisalignW=1 is registered for one W cycle.
REQ-028 Without MISALIGN_TRAP_EN: MisalignW is absent, and misaligned accesses use the REQ-017/019 lanes from the truncated offset.

Structure
REQ-029 Package lsu_pkg holds the state enum, the Funct3 load/store width constants and the ResultSrc encodings (00 ALU, 01 memory, 10 PC+4).
REQ-030 Sub-module load_extend, purely combinational, does lane select and extension; the FSM and W register stay in mem_lsu.

Verification
REQ-031 sw, addr 0x100, data 0xDEADBEEF, DGnt=1 immediately -> DBe=1111, DWData=0xDEADBEEF, StallM=0, no FSM state change.
REQ-032 lb, addr 0x103, DGnt after 2 cycles, DRValid 1 cycle later with DRData=0x80000000 -> StallM high 3 cycles, RegWriteW=0 during the stall, ReadDataW=0xFFFFFF80.
REQ-033 lhu, addr 0x102, DRData=0x8001_0000 -> ReadDataW=0x00008001. sb, addr 0x101, data 0xAB -> DBe=0010, DWData=0xABABABAB.
REQ-034 RST_N=0 in WAIT_RD, then DRValid=1 after release -> state IDLE, W outputs 0, no writeback.
REQ-035 With MISALIGN_TRAP_EN: lw at 0x102 -> DReq never asserted, MisalignW=1, RegWriteW=0. Without the macro: a bus word read at 0x100.

Source files
------------

// File: rtl/lsu_pkg.sv
// Shared types and encodings for the memory-stage load/store unit.
package lsu_pkg;

    localparam int unsigned WIDTH = 32;
    localparam int unsigned BE_W  = WIDTH / 8;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_WAIT_GNT = 2'd1,
        ST_WAIT_RD  = 2'd2
    } lsu_state_e;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    localparam logic [1:0] RES_ALU = 2'b00;
    localparam logic [1:0] RES_MEM = 2'b01;
    localparam logic [1:0] RES_PC4 = 2'b10;

    // Byte enables for a store of the given size at the given byte offset.
    function automatic logic [BE_W-1:0] store_be(input logic [2:0] f3, input logic [1:0] off);
        case (f3[1:0])
            2'b00:   store_be = BE_W'(4'b0001 << off);
            2'b01:   store_be = BE_W'(4'b0011 << {off[1], 1'b0});
            default: store_be = BE_W'(4'b1111);
        endcase
    endfunction

    // Replicate the store byte/half onto every lane.
    function automatic logic [WIDTH-1:0] store_data(input logic [2:0] f3, input logic [WIDTH-1:0] wd);
        case (f3[1:0])
            2'b00:   store_data = {4{wd[7:0]}};
            2'b01:   store_data = {2{wd[15:0]}};
            default: store_data = wd;
        endcase
    endfunction

endpackage

// File: rtl/mem_lsu_load_extend.sv
// Load lane select and sign/zero extension (combinational).
module load_extend
    import lsu_pkg::*;
(
    input  logic [2:0]       funct3,
    input  logic [1:0]       offset,
    input  logic [WIDTH-1:0] rdata,
    output logic [WIDTH-1:0] rdata_ext
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    // Pick the addressed byte and half from the returned word.
    always_comb begin
        case (offset)
            2'd0:    byte_sel = rdata[7:0];
            2'd1:    byte_sel = rdata[15:8];
            2'd2:    byte_sel = rdata[23:16];
            default: byte_sel = rdata[31:24];
        endcase
        half_sel = offset[1] ? rdata[31:16] : rdata[15:0];
    end

    // Extend according to the load width; unknown widths return the whole word.
    always_comb begin
        case (funct3)
            F3_B:    rdata_ext = {{24{byte_sel[7]}}, byte_sel};
            F3_H:    rdata_ext = {{16{half_sel[15]}}, half_sel};
            F3_BU:   rdata_ext = {24'd0, byte_sel};
            F3_HU:   rdata_ext = {16'd0, half_sel};
            default: rdata_ext = rdata;
        endcase
    end

endmodule

// File: rtl/mem_lsu.sv
// Memory-stage load/store unit: bus handshake FSM, stall generation and
// the M->W pipeline register. Optional macro: MISALIGN_TRAP_EN (misaligned
// half/word accesses are suppressed and flagged on MisalignW).
module mem_lsu
    import lsu_pkg::*;
(
    input  logic               CLK,
    input  logic               RST_N,
    input  logic               RegWriteM,
    input  logic [1:0]         ResultSrcM,
    input  logic               MemWriteM,
    input  logic [2:0]         Funct3M,
    input  logic [WIDTH-1:0]   AluResultM,
    input  logic [WIDTH-1:0]   WriteDataM,
    input  logic [11:7]        RdM,
    input  logic [WIDTH-1:0]   PCPlus4M,
    output logic               DReq,
    output logic               DWe,
    output logic [WIDTH-1:0]   DAddr,
    output logic [BE_W-1:0]    DBe,
    output logic [WIDTH-1:0]   DWData,
    input  logic               DGnt,
    input  logic               DRValid,
    input  logic [WIDTH-1:0]   DRData,
    output logic               StallM,
    output logic               RegWriteW,
    output logic [1:0]         ResultSrcW,
    output logic [WIDTH-1:0]   ReadDataW,
    output logic [WIDTH-1:0]   AluResultW,
    output logic [11:7]        RdW,
    output logic [WIDTH-1:0]   PCPlus4W
`ifdef MISALIGN_TRAP_EN
    ,
    output logic               MisalignW
`endif
);

    lsu_state_e state_q, state_d;

    logic             is_load;
    logic             is_store;
    logic             misalign;
    logic             access;
    logic             load_done;
    logic             dreq;
    logic             stall;
    logic [WIDTH-1:0] rdata_ext;

    logic             regwrite_w_q, regwrite_w_d;
    logic [1:0]       resultsrc_w_q, resultsrc_w_d;
    logic [WIDTH-1:0] readdata_w_q, readdata_w_d;
    logic [WIDTH-1:0] aluresult_w_q, aluresult_w_d;
    logic [11:7]      rd_w_q, rd_w_d;
    logic [WIDTH-1:0] pcplus4_w_q, pcplus4_w_d;
    logic             misalign_w_q, misalign_w_d;

    assign is_load  = (ResultSrcM == RES_MEM);
    assign is_store = MemWriteM;

    // Misalignment check (half on odd byte, word off a word boundary).
`ifdef MISALIGN_TRAP_EN
    assign misalign = (is_load || is_store) &&
                      (((Funct3M[1:0] == 2'b01) && AluResultM[0]) ||
                       (Funct3M[1] && (AluResultM[1:0] != 2'b00)));
`else
    assign misalign = 1'b0;
`endif

    assign access = (is_load || is_store) && !misalign;

    // Bus request shaping; upstream is frozen while pending so these stay stable.
    assign DReq   = dreq;
    assign DWe    = dreq && is_store && !is_load;
    assign DAddr  = {AluResultM[WIDTH-1:2], 2'b00};
    assign DBe    = store_be(Funct3M, AluResultM[1:0]);
    assign DWData = store_data(Funct3M, WriteDataM);
    assign StallM = stall;

    load_extend u_load_extend (
        .funct3    (Funct3M),
        .offset    (AluResultM[1:0]),
        .rdata     (DRData),
        .rdata_ext (rdata_ext)
    );

    // Handshake FSM next-state, request and stall decode.
    always_comb begin
        state_d   = state_q;
        dreq      = 1'b0;
        stall     = 1'b0;
        load_done = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (access) begin
                    dreq = 1'b1;
                    if (DGnt) begin
                        if (is_load) begin
                            state_d = ST_WAIT_RD;
                            stall   = 1'b1;
                        end
                    end else begin
                        state_d = ST_WAIT_GNT;
                        stall   = 1'b1;
                    end
                end
            end
            ST_WAIT_GNT: begin
                dreq = 1'b1;
                if (DGnt) begin
                    if (is_load) begin
                        state_d = ST_WAIT_RD;
                        stall   = 1'b1;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end else begin
                    stall = 1'b1;
                end
            end
            ST_WAIT_RD: begin
                if (DRValid) begin
                    state_d   = ST_IDLE;
                    load_done = 1'b1;
                end else begin
                    stall = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // W register next value: capture when not stalled, bubble otherwise.
    always_comb begin
        regwrite_w_d  = 1'b0;
        resultsrc_w_d = resultsrc_w_q;
        readdata_w_d  = readdata_w_q;
        aluresult_w_d = aluresult_w_q;
        rd_w_d        = rd_w_q;
        pcplus4_w_d   = pcplus4_w_q;
        misalign_w_d  = 1'b0;
        if (!stall) begin
            regwrite_w_d  = RegWriteM && !misalign;
            resultsrc_w_d = ResultSrcM;
            readdata_w_d  = load_done ? rdata_ext : '0;
            aluresult_w_d = AluResultM;
            rd_w_d        = RdM;
            pcplus4_w_d   = PCPlus4M;
            misalign_w_d  = misalign;
        end
    end

    // State and W register flops with synchronous reset.
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            state_q       <= ST_IDLE;
            regwrite_w_q  <= 1'b0;
            resultsrc_w_q <= '0;
            readdata_w_q  <= '0;
            aluresult_w_q <= '0;
            rd_w_q        <= '0;
            pcplus4_w_q   <= '0;
            misalign_w_q  <= 1'b0;
        end else begin
            state_q       <= state_d;
            regwrite_w_q  <= regwrite_w_d;
            resultsrc_w_q <= resultsrc_w_d;
            readdata_w_q  <= readdata_w_d;
            aluresult_w_q <= aluresult_w_d;
            rd_w_q        <= rd_w_d;
            pcplus4_w_q   <= pcplus4_w_d;
            misalign_w_q  <= misalign_w_d;
        end
    end

    assign RegWriteW  = regwrite_w_q;
    assign ResultSrcW = resultsrc_w_q;
    assign ReadDataW  = readdata_w_q;
    assign AluResultW = aluresult_w_q;
    assign RdW        = rd_w_q;
    assign PCPlus4W   = pcplus4_w_q;

`ifdef MISALIGN_TRAP_EN
    assign MisalignW = misalign_w_q;
`else
    logic unused_misalign;
    assign unused_misalign = misalign_w_q;
`endif

endmodule

// File: tb/tb_mem_lsu.sv
// Directed bench for mem_lsu: store/load vector tables plus handshake,
// reset and misalignment sequences.
module tb_mem_lsu;

    logic        CLK = 1'b0;
    logic        RST_N;
    logic        RegWriteM;
    logic [1:0]  ResultSrcM;
    logic        MemWriteM;
    logic [2:0]  Funct3M;
    logic [31:0] AluResultM;
    logic [31:0] WriteDataM;
    logic [11:7] RdM;
    logic [31:0] PCPlus4M;
    logic        DReq, DWe;
    logic [31:0] DAddr;
    logic [3:0]  DBe;
    logic [31:0] DWData;
    logic        DGnt, DRValid;
    logic [31:0] DRData;
    logic        StallM;
    logic        RegWriteW;
    logic [1:0]  ResultSrcW;
    logic [31:0] ReadDataW, AluResultW, PCPlus4W;
    logic [11:7] RdW;
`ifdef MISALIGN_TRAP_EN
    logic        MisalignW;
`endif

    int checks = 0;
    int errors = 0;
    int stall_cnt;

    always #5 CLK = ~CLK;

    mem_lsu dut (
        .CLK(CLK), .RST_N(RST_N),
        .RegWriteM(RegWriteM), .ResultSrcM(ResultSrcM), .MemWriteM(MemWriteM),
        .Funct3M(Funct3M), .AluResultM(AluResultM), .WriteDataM(WriteDataM),
        .RdM(RdM), .PCPlus4M(PCPlus4M),
        .DReq(DReq), .DWe(DWe), .DAddr(DAddr), .DBe(DBe), .DWData(DWData),
        .DGnt(DGnt), .DRValid(DRValid), .DRData(DRData),
        .StallM(StallM),
        .RegWriteW(RegWriteW), .ResultSrcW(ResultSrcW), .ReadDataW(ReadDataW),
        .AluResultW(AluResultW), .RdW(RdW), .PCPlus4W(PCPlus4W)
`ifdef MISALIGN_TRAP_EN
        , .MisalignW(MisalignW)
`endif
    );

    typedef struct {
        logic [2:0]  f3;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  be;
        logic [31:0] wexp;
    } st_vec_t;

    typedef struct {
        logic [2:0]  f3;
        logic [31:0] addr;
        logic [31:0] rdata;
        logic [31:0] exp;
    } ld_vec_t;

    st_vec_t st_tab[5];
    ld_vec_t ld_tab[9];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic nop();
        RegWriteM = 1'b0; ResultSrcM = 2'b00; MemWriteM = 1'b0; Funct3M = 3'b000;
        AluResultM = '0; WriteDataM = '0; RdM = '0; PCPlus4M = '0;
        DGnt = 1'b0; DRValid = 1'b0; DRData = '0;
    endtask

    task automatic set_load(input logic [2:0] f3, input logic [31:0] addr, input logic [4:0] rd);
        nop();
        RegWriteM = 1'b1; ResultSrcM = 2'b01; Funct3M = f3;
        AluResultM = addr; RdM = rd; PCPlus4M = addr + 32'd4;
    endtask

    task automatic set_store(input logic [2:0] f3, input logic [31:0] addr, input logic [31:0] wd);
        nop();
        MemWriteM = 1'b1; Funct3M = f3; AluResultM = addr; WriteDataM = wd;
    endtask

    initial begin
        st_tab[0] = '{3'b010, 32'h100, 32'hDEADBEEF, 4'b1111, 32'hDEADBEEF};
        st_tab[1] = '{3'b000, 32'h101, 32'h000000AB, 4'b0010, 32'hABABABAB};
        st_tab[2] = '{3'b000, 32'h103, 32'h12345678, 4'b1000, 32'h78787878};
        st_tab[3] = '{3'b001, 32'h102, 32'hCAFE1234, 4'b1100, 32'h12341234};
        st_tab[4] = '{3'b001, 32'h200, 32'h0000BEEF, 4'b0011, 32'hBEEFBEEF};

        ld_tab[0] = '{3'b000, 32'h103, 32'h80000000, 32'hFFFFFF80};
        ld_tab[1] = '{3'b101, 32'h102, 32'h80010000, 32'h00008001};
        ld_tab[2] = '{3'b001, 32'h102, 32'h80010000, 32'hFFFF8001};
        ld_tab[3] = '{3'b001, 32'h100, 32'h12347FFF, 32'h00007FFF};
        ld_tab[4] = '{3'b100, 32'h101, 32'h0000FF00, 32'h000000FF};
        ld_tab[5] = '{3'b000, 32'h101, 32'h00007F00, 32'h0000007F};
        ld_tab[6] = '{3'b010, 32'h104, 32'hCAFEF00D, 32'hCAFEF00D};
        ld_tab[7] = '{3'b011, 32'h100, 32'h11223344, 32'h11223344};
        ld_tab[8] = '{3'b111, 32'h108, 32'h55667788, 32'h55667788};

        // Reset
        nop();
        RST_N = 1'b0;
        repeat (3) tick();
        chk("rst_dreq", 32'(DReq), 32'd0);
        chk("rst_state", 32'(dut.state_q), 32'd0);
        chk("rst_regwrite", 32'(RegWriteW), 32'd0);
        chk("rst_alu_w", AluResultW, 32'd0);
        chk("rst_read_w", ReadDataW, 32'd0);
        RST_N = 1'b1;

        // ALU instruction: no bus activity, full capture into W
        nop();
        RegWriteM = 1'b1; AluResultM = 32'h55; PCPlus4M = 32'h1234; RdM = 5'd3;
        ResultSrcM = 2'b10;
        #1;
        chk("alu_dreq", 32'(DReq), 32'd0);
        chk("alu_stall", 32'(StallM), 32'd0);
        tick();
        chk("alu_regwrite_w", 32'(RegWriteW), 32'd1);
        chk("alu_alu_w", AluResultW, 32'h55);
        chk("alu_pc4_w", PCPlus4W, 32'h1234);
        chk("alu_rd_w", 32'(RdW), 32'd3);
        chk("alu_src_w", 32'(ResultSrcW), 32'd2);
        chk("alu_read_w", ReadDataW, 32'd0);

        // Stores granted immediately
        for (int i = 0; i < 5; i++) begin
            set_store(st_tab[i].f3, st_tab[i].addr, st_tab[i].wdata);
            DGnt = 1'b1;
            RdM = 5'(i + 1);
            #1;
            chk("st_dreq", 32'(DReq), 32'd1);
            chk("st_dwe", 32'(DWe), 32'd1);
            chk("st_daddr", DAddr, {st_tab[i].addr[31:2], 2'b00});
            chk("st_dbe", 32'(DBe), 32'(st_tab[i].be));
            chk("st_dwdata", DWData, st_tab[i].wexp);
            chk("st_stall", 32'(StallM), 32'd0);
            tick();
            chk("st_state", 32'(dut.state_q), 32'd0);
            chk("st_alu_w", AluResultW, st_tab[i].addr);
            chk("st_rd_w", 32'(RdW), 32'(i + 1));
        end

        // Loads granted immediately, data one cycle later
        for (int i = 0; i < 9; i++) begin
            set_load(ld_tab[i].f3, ld_tab[i].addr, 5'(i + 10));
            DGnt = 1'b1;
            #1;
            chk("ld_dreq", 32'(DReq), 32'd1);
            chk("ld_dwe", 32'(DWe), 32'd0);
            chk("ld_daddr", DAddr, {ld_tab[i].addr[31:2], 2'b00});
            chk("ld_stall", 32'(StallM), 32'd1);
            tick();
            chk("ld_bubble", 32'(RegWriteW), 32'd0);
            DGnt = 1'b0; DRValid = 1'b1; DRData = ld_tab[i].rdata;
            #1;
            chk("ld_rd_dreq", 32'(DReq), 32'd0);
            chk("ld_rd_stall", 32'(StallM), 32'd0);
            tick();
            chk("ld_data_w", ReadDataW, ld_tab[i].exp);
            chk("ld_regwrite_w", 32'(RegWriteW), 32'd1);
            chk("ld_rd_w", 32'(RdW), 32'(i + 10));
            chk("ld_src_w", 32'(ResultSrcW), 32'd1);
        end
        nop();
        tick();

        // lb 0x103: grant after two cycles, data one cycle after grant
        set_load(3'b000, 32'h103, 5'd5);
        stall_cnt = 0;
        #1;
        if (StallM) stall_cnt++;
        chk("lb_c0_dreq", 32'(DReq), 32'd1);
        tick();
        chk("lb_c0_bubble", 32'(RegWriteW), 32'd0);
        DRValid = 1'b1; DRData = 32'hFFFFFFFF;
        #1;
        if (StallM) stall_cnt++;
        chk("lb_c1_dreq", 32'(DReq), 32'd1);
        chk("lb_c1_daddr", DAddr, 32'h100);
        tick();
        chk("lb_c1_state", 32'(dut.state_q), 32'd1);
        DRValid = 1'b0; DGnt = 1'b1;
        #1;
        if (StallM) stall_cnt++;
        tick();
        chk("lb_c2_bubble", 32'(RegWriteW), 32'd0);
        DGnt = 1'b0; DRValid = 1'b1; DRData = 32'h80000000;
        #1;
        if (StallM) stall_cnt++;
        chk("lb_c3_dreq", 32'(DReq), 32'd0);
        tick();
        chk("lb_stall_cycles", 32'(stall_cnt), 32'd3);
        chk("lb_data_w", ReadDataW, 32'hFFFFFF80);
        chk("lb_regwrite_w", 32'(RegWriteW), 32'd1);
        chk("lb_rd_w", 32'(RdW), 32'd5);

        // Store with delayed grant: request held stable
        set_store(3'b010, 32'h108, 32'h01020304);
        #1;
        chk("sg_stall0", 32'(StallM), 32'd1);
        chk("sg_dwe0", 32'(DWe), 32'd1);
        tick();
        chk("sg_state", 32'(dut.state_q), 32'd1);
        chk("sg_dreq1", 32'(DReq), 32'd1);
        chk("sg_daddr1", DAddr, 32'h108);
        chk("sg_dwdata1", DWData, 32'h01020304);
        DGnt = 1'b1;
        #1;
        chk("sg_stall_gnt", 32'(StallM), 32'd0);
        tick();
        chk("sg_state_done", 32'(dut.state_q), 32'd0);

        // Grant and read-valid together in IDLE: read-valid ignored
        set_load(3'b010, 32'h10C, 5'd7);
        DGnt = 1'b1; DRValid = 1'b1; DRData = 32'h00000BAD;
        #1;
        chk("gv_stall", 32'(StallM), 32'd1);
        tick();
        chk("gv_state", 32'(dut.state_q), 32'd2);
        DGnt = 1'b0; DRData = 32'h600DF00D;
        #1;
        chk("gv_stall_rd", 32'(StallM), 32'd0);
        tick();
        chk("gv_data_w", ReadDataW, 32'h600DF00D);

        // Reset while waiting for read data
        set_load(3'b010, 32'h110, 5'd9);
        DGnt = 1'b1;
        tick();
        chk("rr_state_pre", 32'(dut.state_q), 32'd2);
        nop();
        RST_N = 1'b0;
        tick();
        chk("rr_alu_w_rst", AluResultW, 32'd0);
        RST_N = 1'b1;
        DRValid = 1'b1; DRData = 32'hA5A5A5A5;
        #1;
        chk("rr_dreq", 32'(DReq), 32'd0);
        chk("rr_stall", 32'(StallM), 32'd0);
        tick();
        chk("rr_state", 32'(dut.state_q), 32'd0);
        chk("rr_regwrite_w", 32'(RegWriteW), 32'd0);
        chk("rr_read_w", ReadDataW, 32'd0);

        // Misaligned word load at 0x102
        set_load(3'b010, 32'h102, 5'd4);
`ifdef MISALIGN_TRAP_EN
        #1;
        chk("mis_dreq", 32'(DReq), 32'd0);
        chk("mis_stall", 32'(StallM), 32'd0);
        tick();
        chk("mis_flag_w", 32'(MisalignW), 32'd1);
        chk("mis_regwrite_w", 32'(RegWriteW), 32'd0);
        chk("mis_alu_w", AluResultW, 32'h102);
        nop();
        tick();
        chk("mis_flag_clr", 32'(MisalignW), 32'd0);
`else
        DGnt = 1'b1;
        #1;
        chk("mis_dreq", 32'(DReq), 32'd1);
        chk("mis_daddr", DAddr, 32'h100);
        chk("mis_dbe", 32'(DBe), 32'hF);
        chk("mis_stall", 32'(StallM), 32'd1);
        tick();
        DGnt = 1'b0; DRValid = 1'b1; DRData = 32'h11223344;
        #1;
        chk("mis_stall_rd", 32'(StallM), 32'd0);
        tick();
        chk("mis_data_w", ReadDataW, 32'h11223344);
        chk("mis_regwrite_w", 32'(RegWriteW), 32'd1);
`endif
        nop();
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
